uart_tx_only: RTL and testbench
===============================

# uart_tx_only

UART transmitter, 8 data bits, LSB first, one start bit, one stop bit, idle-high line. It serialises bytes handed over by a parallel valid/ready interface onto `txd` at a fixed integer clock-to-bit ratio. A one-byte holding register lets frames be sent back-to-back with no idle gap. It is the transmit half of the design's serial link, on the same clock domain as the receive path.

## Interface
- `CLKS_PER_BIT`, 448, clock cycles per serial bit; legal range 2..65535. 448 = 28 × 16, matching the design's 16× receive sampler with a divide-by-28 baud tick.
- `clk` input 1: sole clock; all logic on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `din` input 8: byte to transmit; sampled on the accept edge.
- `din_valid` input 1: `din` holds a byte to send.
- `din_ready` output 1: holding register empty; byte accepted on the edge where `din_valid & din_ready`.
- `txd` output 1: serial line, registered, idle 1.
- `busy` output 1: FSM not in IDLE.
- `done` output 1: one-cycle pulse on completion of each stop bit.

## Operation
- Holding register `hold[7:0]` plus flag `hold_full`.
  - `din_ready = ~hold_full`.
  - Accept sets `hold_full` and loads `hold`.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- **IDLE**: `txd`=1. If `hold_full`, load shifter from `hold`, clear `hold_full`, go to START.
- **START**: `txd`=0 for `CLKS_PER_BIT` cycles, then DATA.
- **DATA**: `txd`=shifter[0] for `CLKS_PER_BIT` cycles, then shift right. A 3-bit bit counter counts 0..7; after bit 7, go to PARITY (macro) or STOP.
- **PARITY**: `txd`=^data (even parity) for `CLKS_PER_BIT` cycles, then STOP.
- **STOP**: `txd`=1 for `CLKS_PER_BIT` cycles. On the last cycle, pulse `done`. If `hold_full`, load shifter and go directly to START with no idle cycle; otherwise go to IDLE.
- Baud counter: 16 bits, cleared on every state entry. The bit boundary occurs at count `CLKS_PER_BIT-1`, after which the counter wraps to 0.
- The new byte is latched into the shifter at frame start, so `hold` may be refilled during any later part of the frame.
- **Simultaneous events**: on an edge where `hold` is drained into the shifter, `din_ready` is low, so no accept occurs. The next byte is accepted no earlier than the following edge.
- `din_valid` while `din_ready`=0 is ignored; the source must hold it.
- **Reset mid-frame**: on the reset edge, the frame is aborted, `hold` is dropped, and `txd` returns to 1. No `done` pulse is produced.

## Timing
- Reset values: `txd`=1, `busy`=0, `done`=0, `din_ready`=1, FSM=IDLE, counters=0.
- **Latency**: byte accepted on edge E while idle.
  - `txd` falls after edge E+1.
  - `busy` rises after edge E+1.
  - `din_ready` returns high after edge E+1.
- **Frame length**: 10×`CLKS_PER_BIT` cycles without the macro, 11×`CLKS_PER_BIT` cycles with it.
- `done` is high for exactly the final cycle of the stop bit.
- **Back-to-back**: the next start bit begins on the cycle immediately after the stop bit's last cycle.
- **Throughput**: one frame per 10 (or 11) bit times when `hold` is kept full.
- **Glitch-free output**: `txd` changes only at bit boundaries.

## Configuration
- `UART_TX_PARITY_EN`:
  - **Defined**: even-parity bit inserted between bit 7 and the stop bit; frame is 11 bits.
  - **Undefined**: PARITY state and its logic are compiled out; 8N1, 10-bit frame.

## Test plan
- **Single byte**: `CLKS_PER_BIT`=16, send 0xA5 from idle.
  - Required response: `txd` = 0,1,0,1,0,0,1,0,1,1, each bit lasting 16 cycles.
  - Fall occurs 1 cycle after accept; `done` pulses at cycle 160 after the fall; then `busy`=0.
- **Back-to-back**: 0x00 then 0xFF, with `din_valid` held.
  - Required response: the second start bit directly follows the first stop bit with no idle cycle.
  - `din_ready` is low only for the 1 cycle in which `hold` is filled (second byte accepted 1 cycle after the first drains).
- **Backpressure**: third byte presented while `hold` is full.
  - Required response: `din_ready`=0 until the second frame starts; the third byte is transmitted intact and bytes leave in order.
- **Parity** (`UART_TX_PARITY_EN`): send 0x07 → parity bit 1; send 0x03 → parity bit 0; frame is 176 cycles at `CLKS_PER_BIT`=16.
- **Reset mid-frame**: assert `rst` for 1 cycle during bit 3 of 0x5A.
  - Required response: `txd`=1 on the next edge, `busy`=0, `din_ready`=1, and no `done` pulse.
  - A byte sent afterwards is transmitted correctly.
- **Loopback**: default `CLKS_PER_BIT`=448, `txd` fed to the 16×-oversampling 8N1 receiver.
  - Send 0x00, 0x55, 0xAA, 0xFF back-to-back; the receiver reports all four bytes in order.

Source files
------------

// File: rtl/uart_tx_only.sv
// uart_tx_only: 8-bit LSB-first UART transmitter with a one-byte holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1 instead of 8N1).
module uart_tx_only #(
  parameter int unsigned CLKS_PER_BIT = 448
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif
  logic        bit_end;
  logic        load;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = bit_end ? 16'd0 : baud_q + 16'd1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    load        = 1'b0;

    if (din_valid && !hold_full_q) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // A waiting byte chains straight into the next start bit, no idle cycle
        if (bit_end) begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      bit_d       = '0;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    if (state_d != state_q) baud_d = '0;
  end

  // txd is registered from the next state so the line moves on the same edge as the FSM
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  assign txd       = txd_q;
  assign din_ready = ~hold_full_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_only.sv
// Testbench for uart_tx_only: fast instance (16 clocks/bit) for framing, timing and reset,
// plus a default-rate instance looped back into a 16x-oversampling receiver model.
module tb_uart_tx_only;

  localparam int TB_CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * TB_CPB;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } VecRec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       dinValid = 1'b0;
  logic       dinReady, txd, busy, done;
  logic [7:0] dinLb = 8'h00;
  logic       dinValidLb = 1'b0;
  logic       dinReadyLb, txdLb, busyLb, doneLb;

  int total = 0;
  int bad = 0;
  int edgeCount = 0;
  int doneTotal = 0;
  int frameCount = 0;
  int abortCount = 0;
  int fallLog[$];
  logic [10:0] lastFrameBits;
  int lastFallEdge;
  logic [7:0] sbQueue[$];
  logic [7:0] lbQueue[$];
  logic [7:0] rxQueue[$];
  int rxErr = 0;

  uart_tx_only #(.CLKS_PER_BIT(TB_CPB)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .din_ready(dinReady),
    .txd(txd), .busy(busy), .done(done)
  );

  uart_tx_only dutLb (
    .clk(clk), .rst(rst), .din(dinLb), .din_valid(dinValidLb), .din_ready(dinReadyLb),
    .txd(txdLb), .busy(busyLb), .done(doneLb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  always @(negedge clk) if (done === 1'b1) doneTotal <= doneTotal + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with din_valid still high.
  task automatic applyStimulus(input logic [7:0] b, input bit toLb, output int waited, output int accEdge);
    waited = 0;
    accEdge = -1;
    if (toLb) begin dinLb = b; dinValidLb = 1'b1; end
    else begin din = b; dinValid = 1'b1; end
    while (((toLb ? dinReadyLb : dinReady) !== 1'b1) && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 6000) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    accEdge = edgeCount - 1;
    if (toLb) lbQueue.push_back(b);
    else sbQueue.push_back(b);
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (frameCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frameCount < target) checkOutput("frame_timeout", frameCount, target);
  endtask

  // Frame monitor: checks every cycle of each frame against the popped scoreboard byte
  logic [7:0]  monExp;
  logic [10:0] monFrame, capBits;
  int monSerialErrs, monDoneErrs, monFall;
  bit monAborted;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst !== 1'b1 && txd === 1'b0) begin
        monFall = edgeCount - 1;
        if (sbQueue.size() == 0) begin
          checkOutput("sb_underflow", 32'd1, 32'd0);
          monExp = 8'h00;
        end else begin
          monExp = sbQueue.pop_front();
        end
`ifdef UART_TX_PARITY_EN
        monFrame = {1'b1, ^monExp, monExp, 1'b0};
`else
        monFrame = {1'b0, 1'b1, monExp, 1'b0};
`endif
        monSerialErrs = 0;
        monDoneErrs = 0;
        monAborted = 1'b0;
        capBits = '0;
        for (int c = 0; c < FRAME_CYC; c++) begin
          if (c != 0) begin @(posedge clk); #1; end
          if (rst === 1'b1) begin monAborted = 1'b1; break; end
          if (txd !== monFrame[c / TB_CPB] || busy !== 1'b1) monSerialErrs++;
          if (done !== (c == FRAME_CYC - 1)) monDoneErrs++;
          if (c % TB_CPB == TB_CPB / 2) capBits[c / TB_CPB] = txd;
        end
        if (monAborted) begin
          abortCount++;
        end else begin
          checkOutput("frame_serial", monSerialErrs, 0);
          checkOutput("frame_done_pulse", monDoneErrs, 0);
          checkOutput("frame_byte", capBits[8:1], monExp);
          lastFrameBits = capBits;
          lastFallEdge = monFall;
          fallLog.push_back(monFall);
          frameCount++;
        end
      end
    end
  end

  // 16x-oversampling receiver on the loopback line: tick every 28 clocks, mid-bit sampling
  int rxTick = 0, rxState = 0, rxSub = 0, rxBit = 0;
  logic [8:0] rxBits = '0;
  always @(negedge clk) begin
    rxTick <= (rxTick == 27) ? 0 : rxTick + 1;
    if (rxTick == 27) begin
      case (rxState)
        0: if (txdLb === 1'b0) begin rxState <= 1; rxSub <= 0; end
        1: if (rxSub == 7) begin
             rxSub <= 0; rxBit <= 0;
             rxState <= (txdLb === 1'b0) ? 2 : 0;
           end else rxSub <= rxSub + 1;
        2: if (rxSub == 15) begin
             rxSub <= 0;
             rxBits[rxBit] <= txdLb;
             if (rxBit == FRAME_BITS - 3) rxState <= 3;
             else rxBit <= rxBit + 1;
           end else rxSub <= rxSub + 1;
        default: if (rxSub == 15) begin
             rxSub <= 0; rxState <= 0;
             if (txdLb !== 1'b1) rxErr <= rxErr + 1;
`ifdef UART_TX_PARITY_EN
             else if (rxBits[8] !== ^rxBits[7:0]) rxErr <= rxErr + 1;
`endif
             else rxQueue.push_back(rxBits[7:0]);
           end else rxSub <= rxSub + 1;
      endcase
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  VecRec vecs[6];
  logic [7:0] lbBytes[4];
  int w, a, w1, w2, w3, a1, a2, a3, base, ab0, d0, lowCnt, n;

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'h54A};
    vecs[1] = '{8'h3C, 11'h478};
    vecs[2] = '{8'h01, 11'h602};
    vecs[3] = '{8'h80, 11'h700};
    vecs[4] = '{8'h07, 11'h60E};
    vecs[5] = '{8'h03, 11'h406};
`else
    vecs[0] = '{8'hA5, 11'h34A};
    vecs[1] = '{8'h3C, 11'h278};
    vecs[2] = '{8'h01, 11'h202};
    vecs[3] = '{8'h80, 11'h300};
    vecs[4] = '{8'h07, 11'h20E};
    vecs[5] = '{8'h03, 11'h206};
`endif
    lbBytes[0] = 8'h00; lbBytes[1] = 8'h55; lbBytes[2] = 8'hAA; lbBytes[3] = 8'hFF;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_din_ready", dinReady, 1);
    checkOutput("reset_lb_txd", txdLb, 1);

    // Single bytes from idle: exact bit pattern, start latency, return to idle
    for (int i = 0; i < 6; i++) begin
      base = frameCount;
      applyStimulus(vecs[i].data, 1'b0, w, a);
      dinValid = 1'b0;
      checkOutput("idle_accept_wait", w, 0);
      waitFrames(base + 1, FRAME_CYC + 100);
      checkOutput("vec_pattern", lastFrameBits, vecs[i].frame);
      checkOutput("vec_fall_latency", lastFallEdge - a, 1);
      @(negedge clk);
      checkOutput("vec_idle_after", {busy, txd}, 2'b01);
    end

    // Back-to-back with din_valid held, then a third byte under backpressure
    base = frameCount;
    applyStimulus(8'h00, 1'b0, w1, a1);
    applyStimulus(8'hFF, 1'b0, w2, a2);
    applyStimulus(8'h96, 1'b0, w3, a3);
    dinValid = 1'b0;
    checkOutput("b2b_ready_low_cycles", w2, 1);
    checkOutput("b2b_accept_gap", a2 - a1, 2);
    checkOutput("bp_accept_edge", a3 - a1, FRAME_CYC + 2);
    waitFrames(base + 3, 3 * FRAME_CYC + 200);
    if (fallLog.size() >= base + 3) begin
      checkOutput("b2b_start_gap", fallLog[base + 1] - fallLog[base], FRAME_CYC);
      checkOutput("bp_start_gap", fallLog[base + 2] - fallLog[base + 1], FRAME_CYC);
    end
    @(negedge clk);
    checkOutput("bp_idle_after", busy, 0);

    // Reset during data bit 3 of 0x5A with a second byte waiting in hold
    base = frameCount;
    ab0 = abortCount;
    applyStimulus(8'h5A, 1'b0, w, a);
    applyStimulus(8'h99, 1'b0, w, a2);
    dinValid = 1'b0;
    repeat (70) @(negedge clk);
    checkOutput("pre_reset_bit3", txd, 1);
    d0 = doneTotal;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_din_ready", dinReady, 1);
    checkOutput("rst_done", done, 0);
    rst = 1'b0;
    if (sbQueue.size() > 0) void'(sbQueue.pop_back());
    lowCnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1) lowCnt++;
    end
    checkOutput("rst_line_idle", lowCnt, 0);
    checkOutput("rst_no_done", doneTotal - d0, 0);
    checkOutput("rst_abort_seen", abortCount - ab0, 1);
    checkOutput("rst_hold_dropped", frameCount - base, 0);
    applyStimulus(8'hC3, 1'b0, w, a);
    dinValid = 1'b0;
    waitFrames(base + 1, FRAME_CYC + 100);

    // Loopback at the default rate into the oversampling receiver
    for (int i = 0; i < 4; i++) applyStimulus(lbBytes[i], 1'b1, w, a);
    dinValidLb = 1'b0;
    n = 0;
    while (rxQueue.size() < 4 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("loopback_count", rxQueue.size(), 4);
    checkOutput("loopback_rx_errors", rxErr, 0);
    while (rxQueue.size() > 0 && lbQueue.size() > 0)
      checkOutput("loopback_byte", rxQueue.pop_front(), lbQueue.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
